pc_return_stack: RTL and testbench
==================================

Name: pc_return_stack

Overview:
- Program-counter unit that sits directly downstream of the branch comparator.
- Consumes the comparator's pcflag, fcall and fcallend outputs plus a branch target, and selects the next PC each cycle: sequential, branch taken, function call, or function return.
- Holds a hardware return-address stack (LIFO) for nested calls.
- Emits a registered redirect pulse so the fetch/decode stages can flush wrong-path instructions.

Parameters:
- AW, 16, PC and target width in bits.
- DEPTH, 8, return-stack entries (power of two, >=2).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 = stall, all state holds.
- br_valid  input  1  current execute-stage instruction is a branch/call/return; qualifies the three flags.
- pcflag  input  1  branch condition true (from comparator).
- fcall  input  1  function call (from comparator).
- fcallend  input  1  function return (from comparator).
- target  input  AW  branch/call destination address.
- pc  output  AW  current program counter (registered).
- redirect  output  1  registered, 1-cycle pulse: the last PC update was non-sequential.
- ret_top  output  AW  address at top of stack; 0 when the stack is empty.
- depth  output  $clog2(DEPTH)+1  number of valid stack entries.
- stk_ovf  output  1  sticky: a call was attempted with the stack full.
- stk_unf  output  1  sticky: a return was attempted with the stack empty.

Behaviour:
- Reset (asynchronous, immediate on rst=1; entry contents are don't-care):
  - pc=RESET_PC, depth=0, redirect=0, stk_ovf=0, stk_unf=0, ret_top=0.
- Stall: en=0 holds pc, depth, stack contents and flags, and forces redirect to 0 at the next edge.
- Flags are ignored when br_valid=0; the PC then advances normally.
- At each rising edge with en=1, the first matching rule applies (fcall > fcallend > pcflag > sequential):
  - 1. br_valid & fcall & depth<DEPTH: push pc+1 (mod 2^AW); pc<=target; depth+1; redirect<=1.
  - 1a. br_valid & fcall & depth==DEPTH: no push, no jump; pc<=pc+1; stk_ovf<=1; redirect<=0.
  - 2. br_valid & fcallend & depth>0: pop; pc<=popped address; depth-1; redirect<=1.
  - 2a. br_valid & fcallend & depth==0: pc<=pc+1; stk_unf<=1; redirect<=0.
  - 3. br_valid & pcflag: pc<=target; redirect<=1. A taken branch to pc+1 still asserts redirect.
  - 4. Otherwise: pc<=pc+1, wrapping 2^AW-1 -> 0; redirect<=0.
- Latency: the new pc is visible one cycle after the qualifying edge. Push/pop and the depth change happen on the same edge.
- Stack implementation: register array indexed by depth.
  - ret_top is combinational from entry[depth-1], or 0 when depth==0.
  - A pushed value is readable on ret_top the cycle after the push.
- stk_ovf/stk_unf are cleared only by rst. They do not block later valid operations.
- Reset asserted mid-call/return discards the in-flight update: stack empties and pc=RESET_PC.
- Addition uses AW-bit arithmetic; carry is discarded.

Test Plan:
- Reset/sequential: rst pulse, en=1, br_valid=0 for 4 cycles -> pc 0,1,2,3,4; redirect=0; depth=0.
- Taken branch: at pc=5, br_valid=1, pcflag=1, target=16'h0040 -> next pc=0x40, redirect=1 for one cycle, then pc=0x41. Same stimulus with pcflag=0 -> pc=6, redirect=0.
- Nested call/return: call at pc=0x10 to target 0x100, then call at 0x100 to 0x200 -> depth=2, ret_top=0x101. Return -> pc=0x101, depth=1, ret_top=0x11. Return -> pc=0x11, depth=0, ret_top=0.
- Overflow/underflow: DEPTH+1 consecutive calls -> last call gives pc=pc+1, stk_ovf=1, depth=8. Then DEPTH+1 returns -> unwinds in LIFO order; final return gives stk_unf=1, pc=pc+1. Both flags stay set until rst.
- Stall and priority: en=0 with fcall=1 for 3 cycles -> pc, depth unchanged, redirect=0. Then en=1 with fcall=1 and pcflag=1 -> call taken (push occurs). Set pc=16'hFFFF with a sequential step -> pc=0.
- Async reset mid-operation: assert rst between edges while depth=3 -> pc=0, depth=0, redirect=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_return_stack.sv
// Program-counter unit: picks the next PC (sequential / branch / call / return)
// and keeps a LIFO of return addresses for nested calls.
module pc_return_stack #(
    parameter int unsigned    AW       = 16,
    parameter int unsigned    DEPTH    = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       br_valid,
    input  logic                       pcflag,
    input  logic                       fcall,
    input  logic                       fcallend,
    input  logic [AW-1:0]              target,
    output logic [AW-1:0]              pc,
    output logic                       redirect,
    output logic [AW-1:0]              ret_top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned DW = IW + 1;

    logic [AW-1:0] stack [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_n;
    logic [DW-1:0] depth_n;
    logic          redirect_n;
    logic          ovf_n;
    logic          unf_n;
    logic          push;
    logic          full;
    logic          empty;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;

    assign pc_inc  = pc + AW'(1);
    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign top_idx = IW'(depth - DW'(1));
    assign wr_idx  = IW'(depth);
    assign ret_top = empty ? '0 : stack[top_idx];

    // Next-state selection; priority fcall > fcallend > pcflag > sequential
    always_comb begin
        pc_n       = pc_inc;
        depth_n    = depth;
        redirect_n = 1'b0;
        ovf_n      = stk_ovf;
        unf_n      = stk_unf;
        push       = 1'b0;
        if (br_valid && fcall) begin
            if (!full) begin
                push       = 1'b1;
                pc_n       = target;
                depth_n    = depth + DW'(1);
                redirect_n = 1'b1;
            end else begin
                ovf_n = 1'b1;
            end
        end else if (br_valid && fcallend) begin
            if (!empty) begin
                pc_n       = stack[top_idx];
                depth_n    = depth - DW'(1);
                redirect_n = 1'b1;
            end else begin
                unf_n = 1'b1;
            end
        end else if (br_valid && pcflag) begin
            pc_n       = target;
            redirect_n = 1'b1;
        end
    end

    // Control state; a stall holds everything but drops redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            depth    <= '0;
            redirect <= 1'b0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else if (en) begin
            pc       <= pc_n;
            depth    <= depth_n;
            redirect <= redirect_n;
            stk_ovf  <= ovf_n;
            stk_unf  <= unf_n;
        end else begin
            redirect <= 1'b0;
        end
    end

    // Entry contents are don't-care after reset; validity is tracked by depth
    always_ff @(posedge clk) begin
        if (en && push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pc_return_stack;

    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          br_valid;
    logic          pcflag;
    logic          fcall;
    logic          fcallend;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic          redirect;
    logic [AW-1:0] ret_top;
    logic [3:0]    depth;
    logic          stk_ovf;
    logic          stk_unf;

    int checks = 0;
    int errors = 0;

    pc_return_stack #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .en(en), .br_valid(br_valid), .pcflag(pcflag),
        .fcall(fcall), .fcallend(fcallend), .target(target), .pc(pc),
        .redirect(redirect), .ret_top(ret_top), .depth(depth),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk[$];
    logic          m_red, m_ovf, m_unf;

    task automatic model_reset();
        m_pc = '0; m_stk.delete(); m_red = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input logic e, bv, pf, fc, fe, input logic [AW-1:0] t);
        m_red = 0;
        if (!e) return;
        if (bv && fc) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 16'd1); m_pc = t; m_red = 1;
            end else begin
                m_pc = m_pc + 16'd1; m_ovf = 1;
            end
        end else if (bv && fe) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back(); m_red = 1;
            end else begin
                m_pc = m_pc + 16'd1; m_unf = 1;
            end
        end else if (bv && pf) begin
            m_pc = t; m_red = 1;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; br_valid = 0; pcflag = 0; fcall = 0; fcallend = 0; target = '0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic e, bv, pf, fc, fe, input logic [AW-1:0] t);
        @(negedge clk);
        en = e; br_valid = bv; pcflag = pf; fcall = fc; fcallend = fe; target = t;
        model_step(e, bv, pf, fc, fe, t);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          e, bv, pf, fc, fe;
        logic [AW-1:0] t;
        logic [AW-1:0] x_pc;
        logic          x_red;
        logic [3:0]    x_depth;
        logic [AW-1:0] x_top;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, bv, pf, fc, fe, input logic [AW-1:0] t,
                                input logic [AW-1:0] xp, input logic xr,
                                input logic [3:0] xd, input logic [AW-1:0] xt);
        vec_t v;
        v.e = e; v.bv = bv; v.pf = pf; v.fc = fc; v.fe = fe; v.t = t;
        v.x_pc = xp; v.x_red = xr; v.x_depth = xd; v.x_top = xt;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] exp_pc;
        rst = 1; en = 0; br_valid = 0; pcflag = 0; fcall = 0; fcallend = 0; target = '0;

        //           e  bv pf fc fe target    pc       red d  ret_top
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0003, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 1, 1, 1, 16'h0077, 16'h0004, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0005, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0040, 16'h0040, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0041, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0040, 16'h0042, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0010, 16'h0010, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0100, 16'h0100, 1, 1, 16'h0011));
        vecs.push_back(mk(1, 1, 0, 1, 0, 16'h0200, 16'h0200, 1, 2, 16'h0101));
        vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0101, 1, 1, 16'h0011));
        vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0011, 1, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0300, 16'h0011, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0300, 16'h0011, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0300, 16'h0011, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0300, 16'h0300, 1, 1, 16'h0012));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0301, 16'h0301, 1, 1, 16'h0012));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 1, 16'h0012));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0012));

        // Reset state
        #2;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_depth", 32'(depth), 32'h0);
        check("reset_redirect", 32'(redirect), 32'h0);
        check("reset_top", 32'(ret_top), 32'h0);
        check("reset_ovf", 32'(stk_ovf), 32'h0);
        check("reset_unf", 32'(stk_unf), 32'h0);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].bv, vecs[i].pf, vecs[i].fc, vecs[i].fe, vecs[i].t);
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].x_pc));
            check($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(vecs[i].x_red));
            check($sformatf("vec%0d_depth", i), 32'(depth), 32'(vecs[i].x_depth));
            check($sformatf("vec%0d_top", i), 32'(ret_top), 32'(vecs[i].x_top));
        end
        check("vec_ovf", 32'(stk_ovf), 32'h0);
        check("vec_unf", 32'(stk_unf), 32'h0);

        // Overflow then underflow: targets 0x1000 + 16*i
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 1, 0, 1, 0, 16'h1000 + 16'(16 * i));
            check("ovf_call_pc", 32'(pc), 32'h1000 + 32'(16 * i));
            check("ovf_call_depth", 32'(depth), 32'(i + 1));
        end
        check("ovf_pre_flag", 32'(stk_ovf), 32'h0);
        step(1, 1, 0, 1, 0, 16'h2000);
        check("ovf_pc", 32'(pc), 32'h1071);
        check("ovf_flag", 32'(stk_ovf), 32'h1);
        check("ovf_redirect", 32'(redirect), 32'h0);
        check("ovf_depth", 32'(depth), 32'd8);
        check("ovf_top", 32'(ret_top), 32'h1061);
        for (int k = 0; k < DEPTH; k++) begin
            exp_pc = (k == DEPTH - 1) ? 16'h0001 : 16'h1000 + 16'(16 * (6 - k)) + 16'h1;
            step(1, 1, 0, 0, 1, 16'h0000);
            check("unw_pc", 32'(pc), 32'(exp_pc));
            check("unw_depth", 32'(depth), 32'(DEPTH - 1 - k));
            check("unw_redirect", 32'(redirect), 32'h1);
        end
        step(1, 1, 0, 0, 1, 16'h0000);
        check("unf_pc", 32'(pc), 32'h0002);
        check("unf_flag", 32'(stk_unf), 32'h1);
        check("unf_redirect", 32'(redirect), 32'h0);
        check("unf_top", 32'(ret_top), 32'h0);
        check("ovf_sticky", 32'(stk_ovf), 32'h1);
        step(1, 1, 0, 1, 0, 16'h0500);
        check("after_flags_call", 32'(pc), 32'h0500);
        check("flags_sticky", 32'({stk_ovf, stk_unf}), 32'h3);

        // Async reset between edges with depth=3
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 16'h0A00 + 16'(i));
        check("pre_rst_depth", 32'(depth), 32'd3);
        check("pre_rst_redirect", 32'(redirect), 32'h1);
        @(negedge clk);
        br_valid = 1; fcall = 1; target = 16'h0BBB;
        #2 rst = 1;
        #1;
        check("arst_pc", 32'(pc), 32'h0);
        check("arst_depth", 32'(depth), 32'h0);
        check("arst_redirect", 32'(redirect), 32'h0);
        check("arst_top", 32'(ret_top), 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_pc", 32'(pc), 32'h0);
        check("arst_hold_depth", 32'(depth), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic e, bv, pf, fc, fe;
            logic [AW-1:0] t;
            e  = ($urandom_range(9) != 0);
            bv = $urandom_range(1);
            pf = $urandom_range(1);
            fc = ($urandom_range(3) == 0);
            fe = ($urandom_range(3) == 0);
            t  = 16'($urandom);
            if (n % 500 == 0) t = 16'hFFFF;
            step(e, bv, pf, fc, fe, t);
            check("rnd_pc", 32'(pc), 32'(m_pc));
            check("rnd_redirect", 32'(redirect), 32'(m_red));
            check("rnd_depth", 32'(depth), 32'(m_stk.size()));
            check("rnd_top", 32'(ret_top), (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'h0);
            check("rnd_ovf", 32'(stk_ovf), 32'(m_ovf));
            check("rnd_unf", 32'(stk_unf), 32'(m_unf));
            if (n % 750 == 749) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
